if_stage_ctrl: RTL and testbench

//  Instruction-fetch stage for the 5-stage MIPS pipeline; sits directly upstream of decode.

---
 rtl/if_stage_ctrl.sv | 83 ++++++++
 tb/tb_if_stage_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage_ctrl.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory combinationally and registers the
// IF/ID pair (instruction, PC+4, valid). One-cycle boot bubble after reset; redirect beats stall.
module if_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redir_valid,
  input  logic [31:0]      redir_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc4,
  output logic             ifid_valid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             misalign,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_sat;
  logic        bubble_sat;

  assign pc_plus4    = pc + 32'd4;
  assign imem_addr   = pc;
  assign flush_idex  = redir_valid;
  assign flush_exmem = redir_valid;
  assign fetch_sat   = (fetch_cnt == CNT_MAX);
  assign bubble_sat  = (bubble_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= 32'd0;
      ifid_valid <= 1'b0;
      misalign   <= 1'b0;
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      case (state)
        BOOT: begin
          // Redirect and stall are deliberately ignored while the pipeline primes.
          ifid_instr <= NOP_INSTR;
          ifid_pc4   <= 32'd0;
          ifid_valid <= 1'b0;
          if (!bubble_sat) bubble_cnt <= bubble_cnt + 1'b1;
          state      <= RUN;
        end
        RUN: begin
          if (redir_valid) begin
            pc         <= {redir_target[31:2], 2'b00};
            ifid_instr <= NOP_INSTR;
            ifid_pc4   <= 32'd0;
            ifid_valid <= 1'b0;
            if (!bubble_sat) bubble_cnt <= bubble_cnt + 1'b1;
            if (redir_target[1:0] != 2'b00) misalign <= 1'b1;
          end else if (!stall) begin
            pc         <= pc_plus4;
            ifid_instr <= imem_data;
            ifid_pc4   <= pc_plus4;
            ifid_valid <= 1'b1;
            if (!fetch_sat) fetch_cnt <= fetch_cnt + 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed plus randomized bench for if_stage_ctrl against a cycle-level behavioural fetch model.
module tb_if_stage_ctrl;

  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             stall = 1'b0;
  logic             redir_valid = 1'b0;
  logic [31:0]      redir_target = 32'd0;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_data;
  logic [31:0]      ifid_instr;
  logic [31:0]      ifid_pc4;
  logic             ifid_valid;
  logic             flush_idex;
  logic             flush_exmem;
  logic             misalign;
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          m_boot;
  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_valid, m_mis;
  int          m_fc, m_bc;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'd0) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_data = mem_f(imem_addr);

  if_stage_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redir_valid(redir_valid),
    .redir_target(redir_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
    .flush_idex(flush_idex), .flush_exmem(flush_exmem), .misalign(misalign),
    .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0;
    m_valid = 0; m_mis = 0; m_fc = 0; m_bc = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".pc"},     imem_addr,       m_pc);
    chk({tag, ".instr"},  ifid_instr,      m_instr);
    chk({tag, ".pc4"},    ifid_pc4,        m_pc4);
    chk({tag, ".valid"},  32'(ifid_valid), 32'(m_valid));
    chk({tag, ".mis"},    32'(misalign),   32'(m_mis));
    chk({tag, ".fcnt"},   32'(fetch_cnt),  32'(m_fc));
    chk({tag, ".bcnt"},   32'(bubble_cnt), 32'(m_bc));
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model at posedge, check registers.
  task automatic step(input string tag, input bit s, input bit r, input logic [31:0] t);
    stall = s; redir_valid = r; redir_target = t;
    #1;
    chk({tag, ".flush_idex"},  32'(flush_idex),  32'(r));
    chk({tag, ".flush_exmem"}, 32'(flush_exmem), 32'(r));
    @(posedge clk);
    if (m_boot) begin
      m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 0;
      if (m_bc < CMAX) m_bc++;
      m_boot = 0;
    end else if (r) begin
      m_pc = {t[31:2], 2'b00};
      m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 0;
      if (m_bc < CMAX) m_bc++;
      if (t[1:0] != 2'b00) m_mis = 1;
    end else if (!s) begin
      m_instr = mem_f(m_pc);
      m_pc4 = m_pc + 32'd4;
      m_valid = 1;
      m_pc = m_pc + 32'd4;
      if (m_fc < CMAX) m_fc++;
    end
    @(negedge clk);
    check_regs(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_regs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Boot bubble then straight-line fetch; first instruction is the T2 pattern.
    step("boot", 0, 0, 0);
    step("t2", 0, 0, 0);
    chk("t2.instr_lit", ifid_instr, 32'h2008_0005);
    chk("t2.pc4_lit",   ifid_pc4,   32'd4);
    for (int i = 0; i < 15; i++) step("run", 0, 0, 0);
    chk("t1.pc40", imem_addr, 32'h40);

    // Asynchronous reset mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("t1.async");
    @(negedge clk);
    rst_n = 1'b1;
    step("t1.boot_redir", 1, 1, 32'h200);
    chk("t1.boot_pc", imem_addr, 32'd0);
    step("t1.f0", 0, 0, 0);
    chk("t1.f0pc4", ifid_pc4, 32'd4);
    step("t1.f4", 0, 0, 0);
    chk("t1.f4pc4", ifid_pc4, 32'd8);

    // Stall at pc 0x8.
    chk("t3.pc8", imem_addr, 32'h8);
    for (int i = 0; i < 3; i++) step("t3.stall", 1, 0, 0);
    step("t3.resume", 0, 0, 0);
    chk("t3.pcC", imem_addr, 32'hC);

    // Redirect to 0x100.
    step("t4.redir", 0, 1, 32'h100);
    chk("t4.pc", imem_addr, 32'h100);
    step("t4.first", 0, 0, 0);
    chk("t4.pc4", ifid_pc4, 32'h104);
    chk("t4.valid", 32'(ifid_valid), 32'd1);

    // Redirect with stall, aligned then misaligned.
    step("t5.rs", 1, 1, 32'h80);
    chk("t5.pc", imem_addr, 32'h80);
    step("t5.mis", 1, 1, 32'h82);
    chk("t5.mispc", imem_addr, 32'h80);
    chk("t5.misbit", 32'(misalign), 32'd1);
    step("t5.run", 0, 0, 0);
    chk("t5.sticky", 32'(misalign), 32'd1);

    // PC wrap.
    step("t6.redir", 0, 1, 32'hFFFF_FFFC);
    step("t6.wrap", 0, 0, 0);
    chk("t6.pc0", imem_addr, 32'd0);
    chk("t6.pc4_0", ifid_pc4, 32'd0);

    // Counter saturation.
    for (int i = 0; i < 70; i++) step("sat.f", 0, 0, 0);
    chk("sat.fetch", 32'(fetch_cnt), CMAX);
    for (int i = 0; i < 70; i++) step("sat.b", 0, 1, 32'h40);
    chk("sat.bubble", 32'(bubble_cnt), CMAX);

    // Random traffic after a fresh reset so counters move again.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("rnd.reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bit s, r;
      logic [31:0] t;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) == 0);
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      step("rnd", s, r, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
